// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Level both PS/2 lines rest at when the bus is idle (open-collector pull-up).
  localparam logic PS2_IDLE_LVL = 1'b1;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead FIFO holding received bytes; head is visible on dout while not empty.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin sync/filter, start/data/parity/stop deframing,
// stall timeout and a small byte FIFO towards the scan-code decoder.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          kbd_clk,
  input  logic                          kbd_dat,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          dout_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam parity_mode_t PMODE = parity_mode_t'(PARITY_MODE);

  logic [1:0] pin_raw;
  logic [1:0] pin_filt;
  logic       fclk;
  logic       fdat;
  logic       fclk_q;
  logic       fall;
  logic       clk_edge;

  assign pin_raw = {kbd_dat, kbd_clk};

  // Index 0 is the PS/2 clock, index 1 the PS/2 data line.
  for (genvar g = 0; g < 2; g++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync;
    logic [FCW-1:0]         fcnt;
    logic                   filt;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        sync <= {SYNC_STAGES{PS2_IDLE_LVL}};
        fcnt <= '0;
        filt <= PS2_IDLE_LVL;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], pin_raw[g]};
        if (sync[SYNC_STAGES-1] == filt) begin
          fcnt <= '0;
        end else if (fcnt == FCW'(FILT_LEN - 1)) begin
          filt <= sync[SYNC_STAGES-1];
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end

    assign pin_filt[g] = filt;
  end

  assign fclk     = pin_filt[0];
  assign fdat     = pin_filt[1];
  assign fall     = fclk_q & ~fclk;
  assign clk_edge = fclk_q ^ fclk;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) fclk_q <= PS2_IDLE_LVL;
    else         fclk_q <= fclk;
  end

  rx_state_t             state;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;
  logic [TW-1:0]         tcnt;
  logic                  par_ok;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;

  always_comb begin
    par_ok = 1'b1;
    case (PMODE)
      PAR_ODD:  par_ok = ^{shreg, par_bit};
      PAR_EVEN: par_ok = ~^{shreg, par_bit};
      default:  par_ok = 1'b1;
    endcase
  end

  assign push = (state == ST_STOP) && fall && fdat && par_ok;

  // Timeout only fires on a cycle with no clock edge, so it can never race the stop strobe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state == ST_IDLE || clk_edge) tcnt <= '0;
      else                              tcnt <= tcnt + 1'b1;

      if (state != ST_IDLE && !clk_edge && tcnt == TW'(TIMEOUT_CYC - 1)) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!fdat) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {fdat, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1))
              state <= (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= fdat;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!fdat)        frame_err  <= 1'b1;
            else if (!par_ok) parity_err <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) overflow <= 1'b0;
    else         overflow <= push && fifo_full && !(rd_en && !fifo_empty);
  end

  ps2_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (push),
    .din    (shreg),
    .pop    (rd_en),
    .dout   (dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign dout_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: bit-banged PS/2 frames, expected bytes and error counts scoreboarded.
module tb_ps2_frame_rx;
  import ps2_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 15;

  logic       clk = 1'b0;
  logic       resetN;
  logic       kbd_clk;
  logic       kbd_dat;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] fifo_count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0, multi_cnt = 0;
  int exp_par = 0, exp_frm = 0, exp_ovf = 0;
  logic [7:0] exp_q[$];

  ps2_frame_rx #(
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .TIMEOUT_CYC (TIMEOUT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .kbd_clk    (kbd_clk),
    .kbd_dat    (kbd_dat),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetN) begin
      if (parity_err) par_cnt++;
      if (frame_err)  frm_cnt++;
      if (overflow)   ovf_cnt++;
      if (int'(parity_err) + int'(frame_err) + int'(overflow) > 1) multi_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Sends the first nbits of {stop, parity, data, start}; optional 2-cycle kbd_clk glitch after bit glitch_bit.
  task automatic send_bits(input logic [7:0] d, input logic p, input logic stp,
                           input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {stp, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd_dat = f[i];
      repeat (HALF) @(negedge clk);
      kbd_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      kbd_clk = 1'b1;
      if (i == glitch_bit) begin
        repeat (5) @(negedge clk);
        kbd_clk = 1'b0;
        repeat (2) @(negedge clk);
        kbd_clk = 1'b1;
      end
    end
    kbd_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] d, input int glitch_bit);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else                      exp_ovf++;
    send_bits(d, odd_par(d), 1'b1, 11, glitch_bit);
  endtask

  task automatic check_counts(input string tag);
    check({tag, " parity_err count"}, par_cnt, exp_par);
    check({tag, " frame_err count"},  frm_cnt, exp_frm);
    check({tag, " overflow count"},   ovf_cnt, exp_ovf);
    check({tag, " fifo_count"},       fifo_count, exp_q.size());
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " dout_valid"}, dout_valid, 1);
      check({tag, " dout"}, dout, e);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    resetN  = 1'b0;
    kbd_clk = 1'b1;
    kbd_dat = 1'b1;
    rd_en   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset dout", dout, 0);
    check("reset dout_valid", dout_valid, 0);
    check("reset fifo_count", fifo_count, 0);
    check("reset pulses", {parity_err, frame_err, overflow}, 0);
    resetN = 1'b1;
    repeat (10) @(negedge clk);

    // 1: good odd-parity frame 0x1C (parity bit 0)
    send_good(8'h1C, -1);
    check_counts("t1");
    read_check("t1");

    // 2: 0x1C with wrong parity bit
    send_bits(8'h1C, 1'b1, 1'b1, 11, -1);
    exp_par++;
    check_counts("t2");

    // 3: bad stop bit, then good 0xF0
    send_bits(8'h33, odd_par(8'h33), 1'b0, 11, -1);
    exp_frm++;
    check_counts("t3 bad stop");
    send_good(8'hF0, -1);
    check_counts("t3 good");
    read_check("t3");

    // 4: stall after 4 data bits, then 0x5A
    send_bits(8'h0B, 1'b0, 1'b1, 5, -1);
    check("t4 no early abort", frm_cnt, exp_frm);
    repeat (TIMEOUT + 50) @(negedge clk);
    exp_frm++;
    check_counts("t4 timeout");
    check("t4 fsm idle", 32'(dut.state), 32'(ST_IDLE));
    send_good(8'h5A, -1);
    check_counts("t4 good");
    read_check("t4");

    // 5: DEPTH+1 frames without reading
    send_good(8'h11, -1);
    send_good(8'h22, -1);
    send_good(8'h33, -1);
    send_good(8'h44, -1);
    send_good(8'h55, -1);
    check_counts("t5 full");
    for (int i = 0; i < DEPTH; i++) read_check("t5 drain");
    check("t5 empty valid", dout_valid, 0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    check("t5 pop on empty", fifo_count, 0);

    // 6: glitches on kbd_clk in idle and mid-frame
    kbd_clk = 1'b0;
    repeat (2) @(negedge clk);
    kbd_clk = 1'b1;
    repeat (20) @(negedge clk);
    check("t6 idle glitch state", 32'(dut.state), 32'(ST_IDLE));
    check_counts("t6 idle glitch");
    send_good(8'hAA, 3);
    check_counts("t6 frame");
    read_check("t6");

    check("single pulse per cycle", multi_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
